// File: rtl/bt656_capture_ctrl_if.sv
// AXI-Stream-style byte channel carrying captured active video toward the frame-buffer DMA.
interface bt656_capture_ctrl_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tuser;
    logic       tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/bt656_capture_ctrl.sv
// BT.656 timing-code decoder, line/field geometry counters and frame-gated stream capture.
// Define BT656_PARITY_CHECK_EN to also reject XY codes whose protection bits are wrong.
module bt656_capture_ctrl #(
    parameter int unsigned PIX_W  = 12,
    parameter int unsigned LINE_W = 11,
    parameter int unsigned FRM_W  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [7:0]            bt656_data_i,
    input  logic                  bt656_en_i,
    input  logic                  ctrl_start_i,
    input  logic                  ctrl_stop_i,
    input  logic                  ctrl_continuous_i,
    input  logic                  ctrl_clr_i,
    bt656_capture_ctrl_if.master  m,
    output logic                  busy_o,
    output logic                  field_o,
    output logic                  vblank_o,
    output logic [PIX_W-1:0]      line_len_o,
    output logic [LINE_W-1:0]     frame_lines_o,
    output logic [FRM_W-1:0]      frame_cnt_o,
    output logic                  code_err_o,
    output logic                  overflow_o
);

    typedef enum logic [1:0] {SdScan, SdFf, SdZ1, SdZ2} sd_state_e;
    typedef enum logic [1:0] {CIdle, CArmed, CActive} cap_state_e;

    sd_state_e  sd_q, sd_d;
    cap_state_e cap_q, cap_d;

    logic xy_strobe, par_ok, code_ok, code_bad, sav, eav, frame_bnd;
    logic is_ff, active_byte, fwd_byte, eav_ff, out_free, present, ovf_set, fcnt_inc;
    logic field_q, vblank_q, win_q, win_d, fwd_q, fwd_d, stop_q, stop_d, sof_q, sof_d;
    logic err_q, ovf_q;
    logic [PIX_W-1:0]  cnt_q, cnt_d, len_q, len_d;
    logic [LINE_W-1:0] line_q, line_d, flines_q, flines_d;
    logic [FRM_W-1:0]  fcnt_q, fcnt_d;
    logic       hold_v_q, hold_v_d, hold_user_q, hold_user_d;
    logic [7:0] hold_data_q, hold_data_d;
    logic       out_v_q, out_v_d, out_user_q, out_user_d, out_last_q, out_last_d;
    logic [7:0] out_data_q, out_data_d;

    assign is_ff = (bt656_data_i == 8'hFF);

    always_comb begin
        sd_d      = sd_q;
        xy_strobe = 1'b0;
        if (bt656_en_i) begin
            unique case (sd_q)
                SdScan:  if (is_ff) sd_d = SdFf;
                SdFf:    sd_d = (bt656_data_i == 8'h00) ? SdZ1 : SdScan;
                SdZ1:    sd_d = (bt656_data_i == 8'h00) ? SdZ2 : (is_ff ? SdFf : SdScan);
                SdZ2: begin
                    if (is_ff) begin
                        sd_d = SdFf;
                    end else begin
                        xy_strobe = 1'b1;
                        sd_d      = SdScan;
                    end
                end
                default: sd_d = SdScan;
            endcase
        end
    end

`ifdef BT656_PARITY_CHECK_EN
    assign par_ok = (bt656_data_i[3:0] == {bt656_data_i[5] ^ bt656_data_i[4],
                                           bt656_data_i[6] ^ bt656_data_i[4],
                                           bt656_data_i[6] ^ bt656_data_i[5],
                                           bt656_data_i[6] ^ bt656_data_i[5] ^ bt656_data_i[4]});
`else
    assign par_ok = 1'b1;
`endif

    assign code_ok   = xy_strobe & bt656_data_i[7] & par_ok;
    assign code_bad  = xy_strobe & ~code_ok;
    assign sav       = code_ok & ~bt656_data_i[4];
    assign eav       = code_ok & bt656_data_i[4];
    assign frame_bnd = sav & ~bt656_data_i[5] & ~bt656_data_i[6] & vblank_q;
    // Video bytes are never FF, so an FF inside the window is the start of the closing EAV.
    assign active_byte = bt656_en_i & (sd_q == SdScan) & ~is_ff & win_q;
    assign eav_ff      = bt656_en_i & (sd_q == SdScan) & is_ff & win_q;
    assign fwd_byte    = active_byte & fwd_q;

    always_comb begin
        win_d = win_q;
        cnt_d = cnt_q;
        len_d = len_q;
        if (sav) begin
            win_d = 1'b1;
            cnt_d = '0;
        end else if (eav) begin
            win_d = 1'b0;
            if (win_q) len_d = cnt_q;
        end else if (active_byte && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        cap_d    = cap_q;
        stop_d   = stop_q;
        line_d   = line_q;
        flines_d = flines_q;
        fcnt_inc = 1'b0;
        sof_d    = fwd_byte ? 1'b0 : sof_q;
        unique case (cap_q)
            CIdle:   if (ctrl_start_i) cap_d = CArmed;
            CArmed: begin
                if (ctrl_stop_i) begin
                    cap_d = CIdle;
                end else if (frame_bnd) begin
                    cap_d  = CActive;
                    line_d = '0;
                    sof_d  = 1'b1;
                end
            end
            CActive: begin
                if (ctrl_stop_i) stop_d = 1'b1;
                if (eav && !bt656_data_i[5]) line_d = line_q + 1'b1;
                if (frame_bnd) begin
                    flines_d = line_q;
                    fcnt_inc = 1'b1;
                    if (ctrl_continuous_i && !stop_q) begin
                        line_d = '0;
                        sof_d  = 1'b1;
                    end else begin
                        cap_d = CIdle;
                    end
                end
            end
            default: cap_d = CIdle;
        endcase
        if (cap_d == CIdle) stop_d = 1'b0;

        fwd_d = fwd_q;
        if (sav)      fwd_d = ~bt656_data_i[5] & (cap_d == CActive);
        else if (eav) fwd_d = 1'b0;

        if (ctrl_clr_i)    fcnt_d = '0;
        else if (fcnt_inc) fcnt_d = fcnt_q + 1'b1;
        else               fcnt_d = fcnt_q;
    end

    // One-byte hold so tlast can be attached once the EAV reveals the line end.
    assign out_free = ~out_v_q | m.tready;
    assign present  = (fwd_byte | eav_ff) & hold_v_q;

    always_comb begin
        out_v_d     = out_v_q & ~m.tready;
        out_data_d  = out_data_q;
        out_user_d  = out_user_q;
        out_last_d  = out_last_q;
        hold_v_d    = hold_v_q;
        hold_data_d = hold_data_q;
        hold_user_d = hold_user_q;
        ovf_set     = 1'b0;
        if (present) begin
            hold_v_d = 1'b0;
            if (out_free) begin
                out_v_d    = 1'b1;
                out_data_d = hold_data_q;
                out_user_d = hold_user_q;
                out_last_d = eav_ff;
            end else begin
                ovf_set = 1'b1;
            end
        end
        if (fwd_byte) begin
            hold_v_d    = 1'b1;
            hold_data_d = bt656_data_i;
            hold_user_d = sof_q;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            sd_q <= SdScan;       cap_q <= CIdle;
            field_q <= 1'b0;      vblank_q <= 1'b0;
            win_q <= 1'b0;        fwd_q <= 1'b0;
            stop_q <= 1'b0;       sof_q <= 1'b0;
            cnt_q <= '0;          len_q <= '0;
            line_q <= '0;         flines_q <= '0;
            fcnt_q <= '0;         err_q <= 1'b0;
            ovf_q <= 1'b0;
            hold_v_q <= 1'b0;     hold_data_q <= '0;    hold_user_q <= 1'b0;
            out_v_q <= 1'b0;      out_data_q <= '0;
            out_user_q <= 1'b0;   out_last_q <= 1'b0;
        end else begin
            sd_q <= sd_d;         cap_q <= cap_d;
            if (code_ok) begin
                field_q  <= bt656_data_i[6];
                vblank_q <= bt656_data_i[5];
            end
            win_q <= win_d;       fwd_q <= fwd_d;
            stop_q <= stop_d;     sof_q <= sof_d;
            cnt_q <= cnt_d;       len_q <= len_d;
            line_q <= line_d;     flines_q <= flines_d;
            fcnt_q <= fcnt_d;
            err_q <= ~ctrl_clr_i & (err_q | code_bad);
            ovf_q <= ~ctrl_clr_i & (ovf_q | ovf_set);
            hold_v_q <= hold_v_d; hold_data_q <= hold_data_d; hold_user_q <= hold_user_d;
            out_v_q <= out_v_d;   out_data_q <= out_data_d;
            out_user_q <= out_user_d; out_last_q <= out_last_d;
        end
    end

    assign m.tdata       = out_data_q;
    assign m.tvalid      = out_v_q;
    assign m.tuser       = out_user_q;
    assign m.tlast       = out_last_q;
    assign busy_o        = (cap_q != CIdle);
    assign field_o       = field_q;
    assign vblank_o      = vblank_q;
    assign line_len_o    = len_q;
    assign frame_lines_o = flines_q;
    assign frame_cnt_o   = fcnt_q;
    assign code_err_o    = err_q;
    assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_bt656_capture_ctrl.sv
// Directed bench for bt656_capture_ctrl: 16-line synthetic BT.656 frames, scoreboard on the stream.
module tb_bt656_capture_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [7:0]  bt656_data;
    logic        bt656_en, ctrl_start, ctrl_stop, ctrl_continuous, ctrl_clr;
    logic        busy, field, vblank, code_err, overflow;
    logic [11:0] line_len;
    logic [10:0] frame_lines;
    logic [15:0] frame_cnt;

    int n_total = 0;
    int n_pass  = 0;
    int n_tuser = 0;
    logic [9:0]  exp_q[$];
    logic [31:0] mon_exp;

    bt656_capture_ctrl_if axis ();

    bt656_capture_ctrl dut (
        .ACLK              (ACLK),
        .ARESET            (ARESET),
        .bt656_data_i      (bt656_data),
        .bt656_en_i        (bt656_en),
        .ctrl_start_i      (ctrl_start),
        .ctrl_stop_i       (ctrl_stop),
        .ctrl_continuous_i (ctrl_continuous),
        .ctrl_clr_i        (ctrl_clr),
        .m                 (axis),
        .busy_o            (busy),
        .field_o           (field),
        .vblank_o          (vblank),
        .line_len_o        (line_len),
        .frame_lines_o     (frame_lines),
        .frame_cnt_o       (frame_cnt),
        .code_err_o        (code_err),
        .overflow_o        (overflow)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] xy(input logic f, input logic v, input logic h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

    function automatic logic [7:0] pix(input int ln, input int i);
        return 8'(1 + (ln * 7 + i) % 250);
    endfunction

    // One byte per two clocks; tready is held for the whole byte period.
    task automatic put_byte(input logic [7:0] b, input logic rdy);
        bt656_data  = b;
        bt656_en    = 1'b1;
        axis.tready = rdy;
        @(posedge ACLK); #1;
        bt656_en = 1'b0;
        @(posedge ACLK); #1;
    endtask

    task automatic code(input logic [7:0] x);
        put_byte(8'hFF, 1'b1);
        put_byte(8'h00, 1'b1);
        put_byte(8'h00, 1'b1);
        put_byte(x, 1'b1);
    endtask

    task automatic pulse(input int which);
        case (which)
            0: ctrl_start = 1'b1;
            1: ctrl_stop  = 1'b1;
            default: ctrl_clr = 1'b1;
        endcase
        @(posedge ACLK); #1;
        ctrl_start = 1'b0; ctrl_stop = 1'b0; ctrl_clr = 1'b0;
    endtask

    // Lines 1-8 are field 0, 9-16 field 1; V=1 on 1-2, 7-10, 15-16. On stall_ln, tready drops
    // for bytes 20..22, so bytes 20 and 21 are lost while byte 19 waits on the output.
    task automatic send_lines(input int first, input int last, input bit fwd, input int stall_ln);
        logic f, v, stall, lost;
        for (int ln = first; ln <= last; ln++) begin
            f = (ln > 8);
            v = (ln <= 2) || (ln >= 7 && ln <= 10) || (ln >= 15);
            code(xy(f, v, 1'b0));
            for (int i = 0; i < 40; i++) begin
                stall = (ln == stall_ln) && (i >= 20) && (i < 23);
                lost  = (ln == stall_ln) && (i == 20 || i == 21);
                if (fwd && !v && !lost)
                    exp_q.push_back({(ln == 3) && (i == 0), i == 39, pix(ln, i)});
                put_byte(pix(ln, i), !stall);
            end
            code(xy(f, v, 1'b1));
            for (int i = 0; i < 10; i++) put_byte((i % 2 == 1) ? 8'h10 : 8'h80, 1'b1);
        end
    endtask

    always @(negedge ACLK) begin
        if (!ARESET && axis.tvalid && axis.tready) begin
            if (axis.tuser) n_tuser++;
            if (exp_q.size() != 0) mon_exp = {22'd0, exp_q.pop_front()};
            else                   mon_exp = 32'hFFFF_FFFF;
            check("out_byte", {22'd0, axis.tuser, axis.tlast, axis.tdata}, mon_exp);
        end
    end

    initial begin
        ARESET = 1'b1; bt656_data = 8'h00; bt656_en = 1'b0; axis.tready = 1'b1;
        ctrl_start = 1'b0; ctrl_stop = 1'b0; ctrl_continuous = 1'b0; ctrl_clr = 1'b0;
        #1;
        check("rst_axis", {axis.tvalid, axis.tuser, axis.tlast, axis.tdata}, 0);
        check("rst_status", {busy, field, vblank, code_err, overflow}, 0);
        check("rst_counts", {line_len, frame_lines}, 0);
        @(posedge ACLK); @(posedge ACLK); #1;
        ARESET = 1'b0;

        // Single frame capture
        pulse(0);
        check("t1_busy_armed", busy, 1);
        send_lines(1, 16, 1'b1, 0);
        check("t1_busy_mid", busy, 1);
        check("t1_cnt_mid", frame_cnt, 0);
        check("t1_flags_l16", {field, vblank}, 2'b11);
        send_lines(1, 3, 1'b0, 0);
        check("t1_frame_cnt", frame_cnt, 1);
        check("t1_frame_lines", frame_lines, 8);
        check("t1_line_len", line_len, 40);
        check("t1_busy_done", busy, 0);
        check("t1_sticky", {code_err, overflow}, 0);
        check("t1_drained", exp_q.size(), 0);

        // Continuous mode, stop requested inside the third frame
        pulse(2);
        check("t2_clr", frame_cnt, 0);
        n_tuser = 0;
        ctrl_continuous = 1'b1;
        pulse(0);
        send_lines(4, 16, 1'b0, 0);
        send_lines(1, 16, 1'b1, 0);
        send_lines(1, 16, 1'b1, 0);
        send_lines(1, 5, 1'b1, 0);
        pulse(1);
        send_lines(6, 16, 1'b1, 0);
        check("t2_cnt_f3", frame_cnt, 2);
        send_lines(1, 2, 1'b0, 0);
        check("t2_busy_pre", busy, 1);
        ctrl_continuous = 1'b0;
        send_lines(3, 16, 1'b0, 0);
        check("t2_busy_post", busy, 0);
        check("t2_frame_cnt", frame_cnt, 3);
        check("t2_frame_lines", frame_lines, 8);
        check("t2_tuser", n_tuser, 3);
        check("t2_drained", exp_q.size(), 0);

        // Arm in the middle of a field: wait for the next field-0 first active line
        pulse(2);
        send_lines(1, 5, 1'b0, 0);
        pulse(0);
        check("t3_busy", busy, 1);
        send_lines(6, 16, 1'b0, 0);
        check("t3_cnt_wait", frame_cnt, 0);
        send_lines(1, 16, 1'b1, 0);
        send_lines(1, 3, 1'b0, 0);
        check("t3_frame_cnt", frame_cnt, 1);
        check("t3_busy_done", busy, 0);
        check("t3_drained", exp_q.size(), 0);

        // Backpressure on line 3
        pulse(2);
        pulse(0);
        send_lines(4, 16, 1'b0, 0);
        send_lines(1, 2, 1'b0, 0);
        check("t4_ovf_before", overflow, 0);
        send_lines(3, 3, 1'b1, 3);
        check("t4_ovf_after", overflow, 1);
        check("t4_line_len", line_len, 40);
        send_lines(4, 16, 1'b1, 0);
        send_lines(1, 3, 1'b0, 0);
        check("t4_frame_cnt", frame_cnt, 1);
        check("t4_frame_lines", frame_lines, 8);
        check("t4_drained", exp_q.size(), 0);

        // Malformed and unprotected codes
        pulse(2);
        check("t5_clr", {code_err, overflow, frame_cnt}, 0);
        code(xy(1'b0, 1'b0, 1'b1));
        code(8'h70);
        check("t5_err70", code_err, 1);
        check("t5_flags70", {field, vblank}, 2'b00);
        pulse(2);
        check("t5_err_clr", code_err, 0);
        code(xy(1'b0, 1'b1, 1'b1));
        check("t5_v1", vblank, 1);
        code(8'h81);
`ifdef BT656_PARITY_CHECK_EN
        check("t5_err81", code_err, 1);
        check("t5_flags81", {field, vblank}, 2'b01);
`else
        check("t5_err81", code_err, 0);
        check("t5_flags81", {field, vblank}, 2'b00);
`endif

        // Asynchronous reset in the middle of a captured line with the output stalled
        pulse(0);
        send_lines(1, 2, 1'b0, 0);
        code(xy(1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 10; i++) put_byte(pix(3, i), 1'b0);
        check("t6_valid_pre", axis.tvalid, 1);
        #2 ARESET = 1'b1;
        #1;
        check("t6_rst_axis", {axis.tvalid, axis.tuser, axis.tlast, axis.tdata}, 0);
        check("t6_rst_status", {busy, field, vblank, code_err, overflow}, 0);
        check("t6_rst_counts", {frame_cnt, frame_lines}, 0);
        check("t6_rst_len", line_len, 0);
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        axis.tready = 1'b1;
        pulse(0);
        send_lines(1, 16, 1'b1, 0);
        send_lines(1, 3, 1'b0, 0);
        check("t6_frame_cnt", frame_cnt, 1);
        check("t6_frame_lines", frame_lines, 8);
        check("t6_line_len", line_len, 40);
        check("t6_busy_done", busy, 0);
        check("t6_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bt656_capture_ctrl.md
Name: bt656_capture_ctrl

Overview:
- Sequences capture of a BT.656 byte stream into an AXI-Stream-style output under software control.
- Decodes the timing reference codes (FF 00 00 XY) and tracks the F/V/H flags.
- Measures line and field geometry.
- Gates active-video bytes into frames delimited by start-of-frame (tuser) and end-of-line (tlast) markers.
- Sits between the BT.656 source (camera or stream generator) and the frame-buffer DMA.

Parameters:
- PIX_W, 12: width of the per-line byte counter (max 4095 bytes per line).
- LINE_W, 11: width of the line counter (max 2047 lines per frame).
- FRM_W, 16: width of the captured-frame counter.

Ports:
- ACLK  in  1  system clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- bt656_data_i  in  8  BT.656 byte.
- bt656_en_i  in  1  byte strobe; byte is valid when high (one per LLC tick).
- ctrl_start_i  in  1  single-cycle pulse: arm capture.
- ctrl_stop_i  in  1  single-cycle pulse: stop after the current frame.
- ctrl_continuous_i  in  1  1 = re-arm automatically after each frame; 0 = single frame.
- ctrl_clr_i  in  1  pulse: clear sticky flags and frame_cnt_o.
- m_tdata  out  8  active-video byte.
- m_tvalid  out  1  output byte valid.
- m_tready  in  1  downstream ready.
- m_tuser  out  1  first byte of a frame.
- m_tlast  out  1  last active byte of a line.
- busy_o  out  1  capture armed or active.
- field_o  out  1  current F flag.
- vblank_o  out  1  current V flag.
- line_len_o  out  PIX_W  active bytes counted between SAV and EAV on the last complete line.
- frame_lines_o  out  LINE_W  active (V=0) lines in the last completed frame.
- frame_cnt_o  out  FRM_W  frames delivered; wraps.
- code_err_o  out  1  sticky: malformed timing code.
- overflow_o  out  1  sticky: byte dropped because of backpressure.

Behaviour:
- Reset (async) forces every output, counter and sticky flag to 0, puts the FSMs in SD_SCAN and C_IDLE, and clears field_o and vblank_o. Only bytes with bt656_en_i=1 are considered.
- Sync decoder states: SD_SCAN -> SD_FF (byte FF) -> SD_Z1 (00) -> SD_Z2 (00) -> XY decode -> SD_SCAN.
  - Any unexpected byte returns the decoder to SD_SCAN. A byte of FF in SD_Z1 or SD_Z2 goes to SD_FF.
  - XY bit7 = 0 means malformed: set code_err_o, ignore the code.
  - Valid XY: F = bit6, V = bit5, H = bit4. field_o and vblank_o update the cycle after the XY byte.
  - H=0 is SAV: open the line window and clear the byte counter.
  - H=1 is EAV: close the window and latch the byte counter into line_len_o.
  - The counter saturates at all-ones.
  - The FF/00/00 preamble bytes are never forwarded.
- Frame boundary: a valid SAV with V=0 and F=0 whose previous decoded code had V=1 (the first active line of field 0).
- Capture FSM:
  - C_IDLE: on ctrl_start_i go to C_ARMED; busy_o=1.
  - C_ARMED: on a frame boundary go to C_ACTIVE. The line counter resets to 0 and the next forwarded byte carries m_tuser=1.
  - C_ACTIVE: forwards every byte inside a V=0 SAV..EAV window.
    - The line counter increments at each EAV with V=0.
    - At the next frame boundary, latch frame_lines_o and increment frame_cnt_o.
    - If continuous is set and no stop is pending, stay in C_ACTIVE; that boundary SAV starts the new frame (m_tuser on its first byte).
    - Otherwise go to C_IDLE with busy_o=0.
  - ctrl_stop_i in C_ARMED goes directly to C_IDLE. In C_ACTIVE it sets stop-pending, which clears on entry to C_IDLE. ctrl_start_i while busy is ignored.
- m_tlast: the active-byte count of a line is unknown until its EAV, so the output stage holds one byte.
  - Held byte with m_tlast=0 is presented when the next active byte arrives.
  - Held byte with m_tlast=1 is presented when the EAV's first FF arrives.
  - Input-to-output latency: 1 byte strobe.
- Handshake:
  - m_tdata, m_tuser and m_tlast are stable while m_tvalid=1 and m_tready=0.
  - If a new byte must be presented while the output is still stalled, drop the new byte and set overflow_o. The pending byte is kept and its flags are not altered.
- A V=1 code or an EAV while no line is open does not emit m_tlast.
- ctrl_clr_i and an increment in the same cycle: clear wins.

Optional Feature:
- Macro BT656_PARITY_CHECK_EN.
- Defined: XY bits3..0 are checked against P3=V^H, P2=F^H, P1=F^V, P0=F^V^H. On mismatch, set code_err_o and ignore the code; F, V, H and the FSMs do not change.
- Undefined: protection bits are ignored; only bit7 is checked.

Test Plan:
- Line geometry: reset, start, continuous=0; stream with 10 hblank bytes, 40 active bytes per line, 16 lines (V=1 on lines 1-2, 7-10, 15-16) -> one frame of 8 lines x 40 bytes; tuser on byte 0 of line 3 only; tlast every 40th byte; frame_lines_o=8; line_len_o=40; frame_cnt_o=1; busy_o=0 after the frame.
- Continuous mode: continuous=1 over 3 frames, stop pulsed mid-frame 3 -> frame_cnt_o=3, exactly 3 tuser pulses, busy_o falls at the frame-4 boundary, no bytes forwarded afterwards.
- Arm mid-frame: start pulsed during line 5 -> nothing forwarded until the next field-0 first active line; then a full frame.
- Backpressure: m_tready low for 3 byte strobes during active video -> overflow_o=1; the held byte is delivered unchanged when tready returns; exactly 2 bytes missing from that line.
- Bad codes: XY=0x70 (bit7=0) -> code_err_o=1, flags unchanged. With BT656_PARITY_CHECK_EN, XY=0x81 -> code_err_o=1. Without the macro, XY=0x81 is accepted as F=0, V=0, H=0 (SAV).
- Async reset asserted mid-line with m_tvalid=1 -> all outputs 0 immediately; after release, behaviour is identical to a fresh start.
